// File: rtl/mpe_result_packer.sv
// Packs the matrix PE's 32-bit result stream into LANES-wide lines and
// queues finished lines in a show-ahead FIFO for NRAM write-back.
module mpe_result_packer #(
  parameter int LANES = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                mpe_result,
  input  logic                       mpe_vld,
  input  logic                       flush,
  output logic [LANES*32-1:0]        out_data,
  output logic [LANES-1:0]           out_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int IDX_W  = $clog2(LANES);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LINE_W = LANES * 32;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] pack_q, pack_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              ovf_q, ovf_d;

  logic [LINE_W-1:0] mem_data_q [DEPTH];
  logic [LANES-1:0]  mem_mask_q [DEPTH];

  logic [LINE_W-1:0] line;
  logic [LANES-1:0]  line_mask;
  logic [LANES:0]    fill_bit;
  logic [CNT_W-1:0]  count;
  logic              line_done, push, pop, full, accept;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    line = pack_q;
    if (mpe_vld) line[int'(idx_q)*32 +: 32] = mpe_result;

    // Mask covers the lanes filled so far, including this cycle's word.
    count    = {1'b0, idx_q} + CNT_W'(mpe_vld);
    fill_bit = '0;
    fill_bit[count] = 1'b1;
    line_mask = fill_bit[LANES-1:0] - {{(LANES-1){1'b0}}, 1'b1};

    line_done = mpe_vld && (idx_q == IDX_W'(LANES - 1));
    push      = line_done || (flush && (mpe_vld || (idx_q != '0)));

    out_valid = (level_q != '0);
    pop       = out_valid && out_ready;
    full      = (level_q == (PTR_W + 1)'(DEPTH));
    accept    = push && (!full || pop);

    idx_d  = idx_q;
    pack_d = pack_q;
    if (push) begin
      idx_d  = '0;
      pack_d = '0;
    end else if (mpe_vld) begin
      idx_d  = idx_q + IDX_W'(1);
      pack_d = line;
    end

    wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + (PTR_W + 1)'(1);
      2'b01:   level_d = level_q - (PTR_W + 1)'(1);
      default: level_d = level_q;
    endcase

    ovf_d = ovf_q || (push && !accept);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      pack_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: FIFO storage has no reset; its contents are only visible through
  // out_valid gating below, so clearing it would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data_q[wr_ptr_q] <= line;
      mem_mask_q[wr_ptr_q] <= line_mask;
    end
  end

  assign out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_mask   = out_valid ? mem_mask_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mpe_result_packer.sv
// Directed self-checking bench for mpe_result_packer: inputs change and
// outputs are sampled on the falling clock edge.
module tb_mpe_result_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  mpe_result;
  logic         mpe_vld;
  logic         flush;
  logic [511:0] out_data;
  logic [15:0]  out_mask;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   fifo_level;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  mpe_result_packer #(.LANES(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mpe_result (mpe_result),
    .mpe_vld    (mpe_vld),
    .flush      (flush),
    .out_data   (out_data),
    .out_mask   (out_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input logic fl);
    mpe_result = w;
    mpe_vld    = 1'b1;
    flush      = fl;
    tick();
    mpe_vld    = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mpe_result = '0;
    mpe_vld    = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", 512'(out_valid), 512'(0));
    check("rst_data", out_data, 512'(0));
    check("rst_mask", 512'(out_mask), 512'(0));
    check("rst_level", 512'(fifo_level), 512'(0));
    check("rst_ovf", 512'(overflow), 512'(0));
    rst_n = 1'b1;
    tick();

    // Full line 1..16, drained immediately
    out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) send(32'(i), 1'b0);
    check("t1_pre_valid", 512'(out_valid), 512'(0));
    send(32'd16, 1'b0);
    check("t1_valid", 512'(out_valid), 512'(1));
    check("t1_lane0", 512'(out_data[31:0]), 512'(1));
    check("t1_lane15", 512'(out_data[511:480]), 512'(16));
    check("t1_mask", 512'(out_mask), 512'(16'hFFFF));
    check("t1_level", 512'(fifo_level), 512'(1));
    tick();
    check("t1_valid_1cyc", 512'(out_valid), 512'(0));
    check("t1_level_end", 512'(fifo_level), 512'(0));

    // Partial line A,B,C then flush; second flush is a no-op
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b0);
    check("t2_no_push_yet", 512'(out_valid), 512'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_valid", 512'(out_valid), 512'(1));
    check("t2_data", out_data, 512'h0000000C_0000000B_0000000A);
    check("t2_mask", 512'(out_mask), 512'(16'h0007));
    tick();
    check("t2_drained", 512'(out_valid), 512'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t2_noop_valid", 512'(out_valid), 512'(0));
    check("t2_noop_level", 512'(fifo_level), 512'(0));

    // 15 words then 16th together with flush: exactly one full line
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(32'h50 + 32'(i), 1'b0);
    send(32'h5F, 1'b1);
    check("t3_level", 512'(fifo_level), 512'(1));
    check("t3_mask", 512'(out_mask), 512'(16'hFFFF));
    check("t3_lane15", 512'(out_data[511:480]), 512'(32'h5F));
    tick();
    check("t3_single_push", 512'(fifo_level), 512'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_drained", 512'(fifo_level), 512'(0));

    // 80 words with write-back stalled: 4 lines kept, 5th dropped
    for (int i = 0; i < 64; i++) send(32'(i), 1'b0);
    check("t4_level4", 512'(fifo_level), 512'(4));
    check("t4_ovf_before", 512'(overflow), 512'(0));
    check("t4_hold_lane0", 512'(out_data[31:0]), 512'(0));
    for (int i = 64; i < 80; i++) send(32'(i), 1'b0);
    check("t4_level_full", 512'(fifo_level), 512'(4));
    check("t4_ovf", 512'(overflow), 512'(1));
    out_ready = 1'b1;
    check("t4_l0_lane0", 512'(out_data[31:0]), 512'(0));
    check("t4_l0_lane15", 512'(out_data[511:480]), 512'(15));
    tick();
    check("t4_l1_lane0", 512'(out_data[31:0]), 512'(16));
    tick();
    check("t4_l2_lane0", 512'(out_data[31:0]), 512'(32));
    tick();
    check("t4_l3_lane0", 512'(out_data[31:0]), 512'(48));
    check("t4_l3_lane15", 512'(out_data[511:480]), 512'(63));
    check("t4_l3_valid", 512'(out_valid), 512'(1));
    tick();
    check("t4_no_5th", 512'(out_valid), 512'(0));
    check("t4_level0", 512'(fifo_level), 512'(0));
    check("t4_ovf_sticky", 512'(overflow), 512'(1));

    // Reset mid-line: 7 words discarded, overflow cleared asynchronously
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h100 + 32'(i), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_ovf", 512'(overflow), 512'(0));
    check("t6_async_valid", 512'(out_valid), 512'(0));
    tick();
    check("t6_rst_valid", 512'(out_valid), 512'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(32'h200 + 32'(i), 1'b0);
    check("t6_level", 512'(fifo_level), 512'(1));
    check("t6_lane0", 512'(out_data[31:0]), 512'(32'h200));
    check("t6_lane15", 512'(out_data[511:480]), 512'(32'h20F));
    check("t6_mask", 512'(out_mask), 512'(16'hFFFF));
    check("t6_ovf", 512'(overflow), 512'(0));

    // Full FIFO, line completes in the same cycle as a pop
    for (int i = 0; i < 48; i++) send(32'h300 + 32'(i), 1'b0);
    check("t5_full", 512'(fifo_level), 512'(4));
    for (int i = 48; i < 63; i++) send(32'h300 + 32'(i), 1'b0);
    out_ready = 1'b1;
    send(32'h33F, 1'b0);
    out_ready = 1'b0;
    check("t5_level_kept", 512'(fifo_level), 512'(4));
    check("t5_ovf", 512'(overflow), 512'(0));
    check("t5_head", 512'(out_data[31:0]), 512'(32'h300));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
